// File: rtl/writeback_wd_mux_pkg.sv
// Shared MemtoReg encodings and default datapath width for the write-back
// data selector and anything that drives or checks it.
package writeback_wd_mux_pkg;

   localparam int WD_WIDTH = 32;

   typedef enum logic [1:0] {
      SEL_AO   = 2'b00,
      SEL_MEM  = 2'b01,
      SEL_PC4  = 2'b10,
      SEL_RSVD = 2'b11
   } memtoreg_e;

endpackage

// File: rtl/writeback_wd_mux_if.sv
// Write-back data bus: source operands and select in, selected/registered data out.
interface writeback_wd_mux_if
   import writeback_wd_mux_pkg::*;
#(
   parameter int WIDTH = WD_WIDTH
);
   logic [WIDTH-1:0] AO;
   logic [WIDTH-1:0] MemData;
   logic [WIDTH-1:0] PC4;
   logic [1:0]       MemtoReg;
   logic             wr_en;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] wd_q;
   logic             wd_valid;
   logic             sel_err;

   modport master (
      output AO, MemData, PC4, MemtoReg, wr_en,
      input  wd, wd_q, wd_valid, sel_err
   );

   modport slave (
      input  AO, MemData, PC4, MemtoReg, wr_en,
      output wd, wd_q, wd_valid, sel_err
   );
endinterface

// File: rtl/writeback_wd_mux_wd_sel_comb.sv
// Pure 3:1 write-data mux; the reserved code and any unknown select yield zero.
module wd_sel_comb
   import writeback_wd_mux_pkg::*;
#(
   parameter int WIDTH = WD_WIDTH
) (
   input  logic [WIDTH-1:0] AO,
   input  logic [WIDTH-1:0] MemData,
   input  logic [WIDTH-1:0] PC4,
   input  logic [1:0]       MemtoReg,
   output logic [WIDTH-1:0] wd
);

   always_comb begin
      wd = '0;
      case (MemtoReg)
         SEL_AO:  wd = AO;
         SEL_MEM: wd = MemData;
         SEL_PC4: wd = PC4;
         default: wd = '0;
      endcase
   end

endmodule

// File: rtl/writeback_wd_mux.sv
// GRF write-data selector: combinational wd for the write port plus a
// registered trace copy, valid bit and sticky illegal-select flag.
module writeback_wd_mux
   import writeback_wd_mux_pkg::*;
#(
   parameter int WIDTH = WD_WIDTH   // must match the bus interface WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   writeback_wd_mux_if.slave bus
);

   logic [WIDTH-1:0] wdSel;
   logic             illegalWr;

   wd_sel_comb #(.WIDTH(WIDTH)) uSel (
      .AO       (bus.AO),
      .MemData  (bus.MemData),
      .PC4      (bus.PC4),
      .MemtoReg (bus.MemtoReg),
      .wd       (wdSel)
   );

   assign bus.wd    = wdSel;
   assign illegalWr = bus.wr_en & (bus.MemtoReg == SEL_RSVD);

   // Trace copy only; the GRF itself consumes the zero-latency wd.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.wd_q     <= '0;
         bus.wd_valid <= 1'b0;
         bus.sel_err  <= 1'b0;
      end else begin
         bus.wd_valid <= bus.wr_en;
         if (bus.wr_en) begin
            bus.wd_q <= wdSel;
         end
         bus.sel_err <= bus.sel_err | illegalWr;
      end
   end

endmodule

// File: tb/tb_writeback_wd_mux.sv
// Self-checking bench for writeback_wd_mux: vector table for the mux, scoreboard for captures.
module tb_writeback_wd_mux;
   import writeback_wd_mux_pkg::*;

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [31:0] ao;
      logic [31:0] mem;
      logic [31:0] pc4;
      logic [31:0] expWd;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [31:0] sbq[$];
   vec_t vecs[7];

   writeback_wd_mux_if #(.WIDTH(32)) bus();

   writeback_wd_mux #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelWd(input logic [1:0] sel, input logic [31:0] ao,
                                            input logic [31:0] mem, input logic [31:0] pc4);
      case (sel)
         2'b00:   return ao;
         2'b01:   return mem;
         2'b10:   return pc4;
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [1:0] sel, input logic we);
      bus.MemtoReg = sel;
      bus.wr_en    = we;
      if (we) sbq.push_back(modelWd(sel, bus.AO, bus.MemData, bus.PC4));
   endtask

   // One rising edge; afterwards the registered copy is compared against the scoreboard.
   task automatic tick(input string name);
      logic        weSeen;
      logic [31:0] exp;
      weSeen = bus.wr_en;
      @(posedge clk);
      #1;
      chk({name, "_valid"}, {31'b0, bus.wd_valid}, {31'b0, weSeen});
      if (weSeen) begin
         if (sbq.size() == 0) begin
            chk({name, "_sb_empty"}, 32'h1, 32'h0);
         end else begin
            exp = sbq.pop_front();
            chk({name, "_wd_q"}, bus.wd_q, exp);
         end
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] heldQ;
      checks   = 0;
      failures = 0;

      // 1. reset only
      reset        = 1'b0;
      bus.AO       = '0;
      bus.MemData  = '0;
      bus.PC4      = '0;
      bus.MemtoReg = 2'b00;
      bus.wr_en    = 1'b0;
      #100;
      chk("rst_wd",       bus.wd, 32'h0);
      chk("rst_wd_q",     bus.wd_q, 32'h0);
      chk("rst_wd_valid", {31'b0, bus.wd_valid}, 32'h0);
      chk("rst_sel_err",  {31'b0, bus.sel_err}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // 2 and 6. combinational select sweep and input tracking
      vecs[0] = '{"sel_ao",   2'b00, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3004, 32'h0000_1234};
      vecs[1] = '{"sel_mem",  2'b01, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3004, 32'hDEAD_BEEF};
      vecs[2] = '{"sel_pc4",  2'b10, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3004, 32'h0000_3004};
      vecs[3] = '{"sel_rsvd", 2'b11, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3004, 32'h0000_0000};
      vecs[4] = '{"trk_zero", 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_3004, 32'h0000_0000};
      vecs[5] = '{"trk_ones", 2'b00, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_3004, 32'hFFFF_FFFF};
      vecs[6] = '{"trk_msb",  2'b00, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_3004, 32'h8000_0000};
      for (int i = 0; i < 7; i++) begin
         bus.AO       = vecs[i].ao;
         bus.MemData  = vecs[i].mem;
         bus.PC4      = vecs[i].pc4;
         bus.MemtoReg = vecs[i].sel;
         #1;
         chk(vecs[i].name, bus.wd, vecs[i].expWd);
      end
      bus.AO = 32'h0000_1234;

      // 3. capture then hold
      @(negedge clk);
      drive(SEL_MEM, 1'b1);
      tick("cap_mem");
      @(negedge clk);
      drive(SEL_AO, 1'b0);
      tick("cap_hold");
      chk("cap_hold_val", bus.wd_q, 32'hDEAD_BEEF);

      // reserved select without write enable must not flag
      @(negedge clk);
      drive(SEL_RSVD, 1'b0);
      tick("rsvd_nowe");
      chk("rsvd_nowe_err", {31'b0, bus.sel_err}, 32'h0);

      // 4. illegal select is sticky
      @(negedge clk);
      drive(SEL_RSVD, 1'b1);
      tick("illegal");
      chk("illegal_err", {31'b0, bus.sel_err}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.AO = 32'h0000_1000 + 32'(i);
         drive(2'(i % 3), 1'b1);
         tick("legal_after");
         chk("sticky_err", {31'b0, bus.sel_err}, 32'h1);
      end

      // 5. async reset between edges
      @(negedge clk);
      heldQ = bus.wd_q;
      chk("pre_rst_nonzero", {31'b0, (heldQ != 32'h0)}, 32'h1);
      drive(SEL_MEM, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_wd_q",     bus.wd_q, 32'h0);
      chk("arst_wd_valid", {31'b0, bus.wd_valid}, 32'h0);
      chk("arst_sel_err",  {31'b0, bus.sel_err}, 32'h0);
      chk("arst_wd_live",  bus.wd, 32'hDEAD_BEEF);
      bus.MemData = 32'h1357_9BDF;
      #1;
      chk("arst_wd_track", bus.wd, 32'h1357_9BDF);
      reset = 1'b1;
      drive(SEL_PC4, 1'b1);
      tick("post_rst");
      chk("post_rst_pc4", bus.wd_q, 32'h0000_3004);
      chk("post_rst_err", {31'b0, bus.sel_err}, 32'h0);

      chk("sb_drained", 32'(sbq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_wd_mux.md
Name: writeback_wd_mux

Overview:
Register-file write-data selector for the single-cycle/P4 datapath write-back point. Chooses among ALU result (AO), data-memory read data (MemData) and return address (PC4) under the 2-bit MemtoReg control. Provides a zero-latency combinational output `wd` for the GRF write port. Also provides a registered copy with a valid bit and a sticky illegal-select flag for debug and trace.

Parameters:
WIDTH, 32, datapath width of all data inputs and outputs.
SEL_AO, 2'b00, MemtoReg code selecting AO.
SEL_MEM, 2'b01, MemtoReg code selecting MemData.
SEL_PC4, 2'b10, MemtoReg code selecting PC4.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
AO  input  WIDTH  ALU output.
MemData  input  WIDTH  DM read data.
PC4  input  WIDTH  PC+4 (link address for jal).
MemtoReg  input  2  write-data source select.
wr_en  input  1  GRF write enable for this cycle; qualifies the registered copy.
wd  output  WIDTH  combinational selected write data.
wd_q  output  WIDTH  registered wd captured when wr_en=1.
wd_valid  output  1  registered wr_en.
sel_err  output  1  sticky flag; set when wr_en=1 with MemtoReg=2'b11.

Behaviour:
- wd is purely combinational, with no clock dependency:
  - MemtoReg=00 -> AO
  - MemtoReg=01 -> MemData
  - MemtoReg=10 -> PC4
  - MemtoReg=11 -> all zeros
- wd updates within the same delta as any input change. It is unaffected by reset.
- Registered path, on each rising clk edge with reset=1:
  - wd_valid <= wr_en.
  - If wr_en=1: wd_q <= wd.
  - Otherwise wd_q holds its value.
- sel_err <= sel_err | (wr_en & MemtoReg==2'b11). Once set it stays set until reset.
- MemtoReg=11 with wr_en=0 does not set sel_err.
- Reset (reset=0, asynchronous, takes effect immediately without waiting for clk):
  - wd_q=0, wd_valid=0, sel_err=0.
- Reset released mid-operation: the first rising edge after reset=1 captures normally.
- No width extension or arithmetic. All inputs are passed bit-exact.
- X/undefined on MemtoReg: wd follows the synthesis default-case branch (zero).

Decomposition:
- Shared package holds:
  - MemtoReg encodings (SEL_AO/SEL_MEM/SEL_PC4, plus SEL_RSVD=2'b11).
  - WIDTH default.
- Controller and testbench import the same codes.
- One natural sub-module, wd_sel_comb: the pure 3:1 combinational mux with zero default.
- The top level adds the capture register and error flag.

Test Plan:
1. Reset only: all inputs 0, reset=0 for 100 ns -> wd=0, wd_q=0, wd_valid=0, sel_err=0.
2. Select sweep: AO=32'h0000_1234, MemData=32'hDEAD_BEEF, PC4=32'h0000_3004.
   - MemtoReg=0 -> wd=32'h0000_1234
   - MemtoReg=1 -> wd=32'hDEAD_BEEF
   - MemtoReg=2 -> wd=32'h0000_3004
   - MemtoReg=3 -> wd=0
   - All results are checked combinationally, with no clock edge needed.
3. Capture: MemtoReg=1, wr_en=1, one clk edge -> wd_q=32'hDEAD_BEEF, wd_valid=1. Then wr_en=0 and MemtoReg=0 -> wd_q stays DEAD_BEEF, wd_valid=0.
4. Illegal select: wr_en=1, MemtoReg=3, one edge -> sel_err=1 and wd_q=0. Then legal selects for 5 cycles -> sel_err stays 1.
5. Async reset mid-run: after scenario 4, drive reset=0 between clock edges -> wd_q, wd_valid and sel_err clear immediately while wd still follows inputs. Release reset; the next edge with wr_en=1, MemtoReg=2 gives wd_q=32'h0000_3004.
6. Input tracking: hold MemtoReg=0 and toggle AO through 0, FFFF_FFFF, 8000_0000 -> wd mirrors each value with zero latency.
